// File: rtl/dm_access_ctrl_pkg.sv
// dm_access_ctrl_pkg
// Shared constants for the data-memory access controller:
//   - dmtype access codes (dm_word .. dm_byte_unsigned)
//   - FSM state encoding
//   - dm_size(): bytes per access type (0 marks an illegal code)
package dm_access_ctrl_pkg;

    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH0  = 2'd1,
        ST_PH1  = 2'd2,
        ST_RSP  = 2'd3
    } dm_state_e;

    function automatic logic [2:0] dm_size(input logic [2:0] t);
        case (t)
            dm_word:                           dm_size = 3'd4;
            dm_halfword, dm_halfword_unsigned: dm_size = 3'd2;
            dm_byte, dm_byte_unsigned:         dm_size = 3'd1;
            default:                           dm_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dm_access_ctrl_lane_map.sv
// dm_lane_map
// Combinational lane mapper for one memory phase of an access.
//   i_off   : byte offset of the access inside its first word
//   i_size  : access size in bytes (1, 2, 4; 0 = illegal -> no lanes)
//   i_phase : 0 = first word, 1 = following (wrapped) word
//   o_be    : byte lane enables for this phase
//   o_idx   : per lane, index of the access byte carried by that lane.
//             Selects store-data bytes and holding-register slots alike.
module dm_lane_map
    import dm_access_ctrl_pkg::*;
(
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_size,
    input  logic            i_phase,
    output logic [3:0]      o_be,
    output logic [3:0][1:0] o_idx
);

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [2:0] w_i;
        // Access byte index seen by lane k: lanes of the second word continue
        // where the first word ran out (byte 4-off onward).
        assign w_i = i_phase ? (3'(k) + 3'd4 - {1'b0, i_off})
                             : (3'(k) - {1'b0, i_off});
        assign o_be[k]  = (i_phase || (2'(k) >= i_off)) && (w_i < i_size);
        assign o_idx[k] = w_i[1:0];
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
// Arbitrates two requesters onto a byte-enabled word RAM, splitting
// misaligned accesses into two word cycles, and returns extended load data.
// Ports:
//   clk, rstn                    : clock, async active-low reset
//   pN_req/we/addr/dmtype/wdata  : requester N access (N = 0, 1)
//   pN_gnt                       : combinational grant (IDLE only)
//   pN_rsp_valid                 : completion pulse to owning port
//   rsp_rdata, rsp_err           : response data / illegal-dmtype flag
//   mem_we/be/waddr/wdata        : memory cycle, from registered state only
//   mem_rdata                    : combinational read of word mem_waddr
// Config: define DM_CTRL_RR_EN for round-robin arbitration, otherwise
// port 0 has fixed priority.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [2:0]    p0_dmtype,
    input  logic [31:0]   p0_wdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [2:0]    p1_dmtype,
    input  logic [31:0]   p1_wdata,
    output logic          p0_gnt,
    output logic          p1_gnt,
    output logic          p0_rsp_valid,
    output logic          p1_rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-3:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    dm_state_e        r_state, w_next;
    logic             r_we, r_port;
    logic [AW-1:0]    r_addr;
    logic [2:0]       r_type;
    logic [31:0]      r_wdata;
    logic [3:0][7:0]  r_hold;

    logic             w_grant, w_p1_win, w_legal, w_split, w_phase, w_mem_act;
    logic [2:0]       w_size;
    logic [3:0]       w_be;
    logic [3:0][1:0]  w_idx;
    logic [31:0]      w_ext;

    // ---------------- arbitration ----------------
    assign w_grant = (r_state == ST_IDLE) && (p0_req || p1_req);

`ifdef DM_CTRL_RR_EN
    logic r_ptr;  // port holding priority on the next tie
    assign w_p1_win = p1_req && (!p0_req || r_ptr);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        r_ptr <= 1'b0;
        else if (w_grant) r_ptr <= ~w_p1_win;
    end
`else
    assign w_p1_win = p1_req && !p0_req;
`endif

    assign p0_gnt = w_grant && !w_p1_win;
    assign p1_gnt = w_grant &&  w_p1_win;

    // ---------------- access decode ----------------
    assign w_size  = dm_size(r_type);
    assign w_legal = (w_size != 3'd0);
    assign w_split = ({2'b00, r_addr[1:0]} + {1'b0, w_size}) > 4'd4;
    assign w_phase = (r_state == ST_PH1);

    dm_lane_map u_lane_map (
        .i_off   (r_addr[1:0]),
        .i_size  (w_size),
        .i_phase (w_phase),
        .o_be    (w_be),
        .o_idx   (w_idx)
    );

    // ---------------- FSM ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (p0_req || p1_req) w_next = ST_PH0;
            ST_PH0:  w_next = w_split ? ST_PH1 : ST_RSP;
            ST_PH1:  w_next = ST_RSP;
            ST_RSP:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_port  <= 1'b0;
            r_addr  <= '0;
            r_type  <= dm_word;
            r_wdata <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_port  <= w_p1_win;
                r_we    <= w_p1_win ? p1_we     : p0_we;
                r_addr  <= w_p1_win ? p1_addr   : p0_addr;
                r_type  <= w_p1_win ? p1_dmtype : p0_dmtype;
                r_wdata <= w_p1_win ? p1_wdata  : p0_wdata;
            end
            if (w_mem_act && !r_we) begin
                for (int k = 0; k < 4; k++)
                    if (w_be[k]) r_hold[w_idx[k]] <= mem_rdata[8*k +: 8];
            end
        end
    end

    // ---------------- memory port ----------------
    // Illegal types still pass through PH0, but with no lanes and no write.
    assign w_mem_act = ((r_state == ST_PH0) || (r_state == ST_PH1)) && w_legal;
    assign mem_be    = w_mem_act ? w_be : 4'b0000;
    assign mem_we    = w_mem_act && r_we;
    assign mem_waddr = r_addr[AW-1:2] + {{(AW-3){1'b0}}, w_phase};

    always_comb begin
        mem_wdata = '0;
        for (int k = 0; k < 4; k++)
            if (mem_be[k]) mem_wdata[8*k +: 8] = r_wdata[8*w_idx[k] +: 8];
    end

    // ---------------- response ----------------
    always_comb begin
        case (r_type)
            dm_word:              w_ext = r_hold;
            dm_halfword:          w_ext = {{16{r_hold[1][7]}}, r_hold[1], r_hold[0]};
            dm_halfword_unsigned: w_ext = {16'h0, r_hold[1], r_hold[0]};
            dm_byte:              w_ext = {{24{r_hold[0][7]}}, r_hold[0]};
            dm_byte_unsigned:     w_ext = {24'h0, r_hold[0]};
            default:              w_ext = '0;
        endcase
    end

    assign p0_rsp_valid = (r_state == ST_RSP) && !r_port;
    assign p1_rsp_valid = (r_state == ST_RSP) &&  r_port;
    assign rsp_err      = (r_state == ST_RSP) && !w_legal;
    assign rsp_rdata    = ((r_state == ST_RSP) && !r_we) ? w_ext : 32'h0;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl
// Randomized and directed bench for dm_access_ctrl against a byte-array
// reference model of the 128-byte memory. Hosts the word RAM itself.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [6:0]  p0_addr, p1_addr;
    logic [2:0]  p0_dmtype, p1_dmtype;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rsp_valid, p1_rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    dm_access_ctrl #(.AW(7)) dut (
        .clk(clk), .rstn(rstn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_dmtype(p0_dmtype), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_dmtype(p1_dmtype), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rsp_valid(p0_rsp_valid), .p1_rsp_valid(p1_rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_be(mem_be), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // ---------------- memory array ----------------
    logic [31:0] ram [32];
    logic [31:0] init_val [32];
    logic        ram_load;

    assign mem_rdata = ram[mem_waddr];

    always @(posedge clk) begin
        if (ram_load) begin
            for (int w = 0; w < 32; w++) ram[w] <= init_val[w];
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++)
                if (mem_be[k]) ram[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [128];

    function automatic int ref_size(input logic [2:0] t);
        case (t)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [2:0] t);
        logic [31:0] v = 0;
        for (int i = 0; i < ref_size(t); i++) v = v | (32'(ref_mem[(a + i) % 128]) << (8 * i));
        if (t == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        if (t == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int port, input logic req, input logic we,
                            input logic [6:0] a, input logic [2:0] t, input logic [31:0] wd);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = a; p0_dmtype = t; p0_wdata = wd;
        end else begin
            p1_req = req; p1_we = we; p1_addr = a; p1_dmtype = t; p1_wdata = wd;
        end
    endtask

    // Observations of the last access, for directed checks.
    logic [3:0]  obs_be0, obs_be1;
    logic [4:0]  obs_wa0, obs_wa1;
    logic [31:0] obs_rdata;

    task automatic access(input int port, input logic we, input logic [6:0] a,
                          input logic [2:0] t, input logic [31:0] wd);
        bit got_gnt = 0;
        bit got_rsp = 0;
        int lat = 0;
        int n_cyc = 0;
        int n_wr = 0;
        int n = ref_size(t);
        bit split = ((int'(a) % 4) + n) > 4;
        obs_be0 = 0; obs_be1 = 0; obs_wa0 = 0; obs_wa1 = 0; obs_rdata = 0;
        @(posedge clk); #1;
        set_port(port, 1'b1, we, a, t, wd);
        for (int g = 0; g < 10 && !got_gnt; g++) begin
            @(negedge clk);
            got_gnt = (port == 0) ? p0_gnt : p1_gnt;
        end
        @(posedge clk); #1;
        set_port(port, 1'b0, 1'b0, 7'h0, 3'h0, 32'h0);
        if (!got_gnt) begin
            chk("gnt_timeout", 0, 1);
            return;
        end
        while (lat < 8 && !got_rsp) begin
            @(negedge clk);
            lat++;
            if (mem_be != 0 || mem_we) begin
                if (n_cyc == 0) begin obs_be0 = mem_be; obs_wa0 = mem_waddr; end
                else            begin obs_be1 = mem_be; obs_wa1 = mem_waddr; end
                n_cyc++;
                if (mem_we) n_wr++;
            end
            got_rsp = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
            if (got_rsp) begin
                obs_rdata = rsp_rdata;
                chk("rsp_other", (port == 0) ? p1_rsp_valid : p0_rsp_valid, 0);
                chk("rsp_err", rsp_err, (n == 0));
                chk($sformatf("rdata a=%h t=%0d", a, t), rsp_rdata,
                    (we || n == 0) ? 32'h0 : ref_load(int'(a), t));
            end
        end
        chk("rsp_seen", got_rsp, 1);
        chk($sformatf("lat a=%h t=%0d", a, t), lat, split ? 3 : 2);
        chk("mem_cycles", n_cyc, (n == 0) ? 0 : (split ? 2 : 1));
        chk("mem_writes", n_wr, (we && n != 0) ? (split ? 2 : 1) : 0);
        if (we) for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 128] = wd[8*i +: 8];
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        int k, rsp_cnt;
        logic exp_p1;
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
        for (int w = 0; w < 32; w++) begin
            init_val[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w+b] = init_val[w][8*b +: 8];
        end
        ram_load = 1'b1;
        do_reset();
        ram_load = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_gnt", {p0_gnt, p1_gnt}, 0);

        // Aligned word
        access(0, 1, 7'h08, 3'd0, 32'hDEAD_BEEF);
        chk("al_be", obs_be0, 4'b1111);
        chk("al_wa", obs_wa0, 2);
        access(0, 0, 7'h08, 3'd0, 0);
        chk("al_ld", obs_rdata, 32'hDEAD_BEEF);

        // Misaligned word
        access(0, 1, 7'h05, 3'd0, 32'h1122_3344);
        chk("mis_be0", obs_be0, 4'b1110);
        chk("mis_wa0", obs_wa0, 1);
        chk("mis_be1", obs_be1, 4'b0001);
        chk("mis_wa1", obs_wa1, 2);
        chk("mis_w1", ram[1][31:8], 24'h22_3344);
        chk("mis_w2", ram[2][7:0], 8'h11);
        access(1, 0, 7'h05, 3'd0, 0);
        chk("mis_ld", obs_rdata, 32'h1122_3344);

        // Wrap halfword
        access(0, 1, 7'h7F, 3'd1, 32'h0000_A55A);
        chk("wrap_w31", ram[31][31:24], 8'h5A);
        chk("wrap_w0", ram[0][7:0], 8'hA5);
        access(0, 0, 7'h7F, 3'd1, 0);
        chk("wrap_lh", obs_rdata, 32'hFFFF_A55A);
        access(1, 0, 7'h7F, 3'd2, 0);
        chk("wrap_lhu", obs_rdata, 32'h0000_A55A);

        // Byte extension
        access(1, 1, 7'h12, 3'd3, 32'h0000_0080);
        access(0, 0, 7'h12, 3'd3, 0);
        chk("lb", obs_rdata, 32'hFFFF_FF80);
        access(0, 0, 7'h12, 3'd4, 0);
        chk("lbu", obs_rdata, 32'h0000_0080);

        // Illegal type store
        access(0, 1, 7'h20, 3'b110, 32'h1234_5678);
        chk("ill_rdata", obs_rdata, 0);

        // Random traffic
        for (int r = 0; r < 150; r++)
            access($urandom_range(0, 1), 1'($urandom), 7'($urandom), 3'($urandom_range(0, 7)), $urandom);
        for (int w = 0; w < 32; w++) chk($sformatf("mem_w%0d", w), ram[w], ref_word(w));

        // Reset during PH1 of a split store
        @(posedge clk); #1;
        set_port(0, 1, 1, 7'h21, 3'd0, 32'hCAFE_F00D);
        @(negedge clk);
        chk("mr_gnt", p0_gnt, 1);
        @(posedge clk); #1;                  // PH0
        set_port(0, 0, 0, 0, 0, 0);
        @(posedge clk); #2 rstn = 1'b0;      // PH1, reset before its write edge
        @(negedge clk);
        chk("mr_we", mem_we, 0);
        chk("mr_be", mem_be, 0);
        chk("mr_wdata", mem_wdata, 0);
        chk("mr_rsp", {p0_rsp_valid, p1_rsp_valid, rsp_err}, 0);
        chk("mr_rdata", rsp_rdata, 0);
        @(posedge clk); #1 rstn = 1'b1;
        rsp_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (p0_rsp_valid || p1_rsp_valid) rsp_cnt++;
        end
        chk("mr_no_rsp", rsp_cnt, 0);
        ref_mem[8'h21] = 8'h0D; ref_mem[8'h22] = 8'hF0; ref_mem[8'h23] = 8'hFE;
        chk("mr_w8", ram[8], ref_word(8));
        chk("mr_w9", ram[9], ref_word(9));

        // Arbitration: both ports request continuously
        do_reset();
        @(posedge clk); #1;
        set_port(0, 1, 0, 7'h00, 3'd0, 0);
        set_port(1, 1, 0, 7'h04, 3'd0, 0);
        k = 0;
        for (int c = 0; c < 60 && k < 6; c++) begin
            @(negedge clk);
            if (p0_gnt || p1_gnt) begin
`ifdef DM_CTRL_RR_EN
                exp_p1 = k[0];
`else
                exp_p1 = 1'b0;
`endif
                chk($sformatf("arb%0d", k), {p0_gnt, p1_gnt}, {~exp_p1, exp_p1});
                k++;
            end
        end
        chk("arb_count", k, 6);
        @(posedge clk); #1;
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
        repeat (6) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
